// File: rtl/ex_muldiv_seq.sv
// Multi-cycle RV32M MUL/DIV sequencer for the EX stage.
// Radix-2 shift-add multiplier and restoring divider over magnitudes, with a
// final sign fix-up. Stalls IF/ID/EX while iterating; flush aborts the op.
module ex_muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  input  logic            hold_in_i,
  output logic            stall_ex_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN - 1){1'b0}}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                neg_q, neg_d;      // product / quotient must be negated
  logic                a_neg_q, a_neg_d;  // remainder takes the dividend sign
  logic [XLEN-1:0]     mcand_q, mcand_d;  // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;      // product; low half doubles as dividend/quotient
  logic [XLEN:0]       rem_q, rem_d;      // partial remainder with borrow bit
  logic [XLEN-1:0]     res_q, res_d;

  // Operand decode at acceptance
  logic            is_div, signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign is_div   = funct3_i[2];
  assign signed_a = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                    (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign signed_b = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign a_neg    = signed_a & op_a_i[XLEN-1];
  assign b_neg    = signed_b & op_b_i[XLEN-1];
  assign abs_a    = a_neg ? (~op_a_i + 1'b1) : op_a_i;
  assign abs_b    = b_neg ? (~op_b_i + 1'b1) : op_b_i;
  assign div_zero = is_div && (op_b_i == '0);
  assign div_ovf  = is_div && !funct3_i[0] && (op_a_i == MinNeg) && (op_b_i == '1);
  assign special  = div_zero || div_ovf;
  // funct3[1] selects remainder for the divide group
  assign special_res = div_zero ? (funct3_i[1] ? op_a_i : '1)
                                : (funct3_i[1] ? '0 : MinNeg);

  // One iteration step of each datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_fix;
  logic [XLEN:0]     div_shift, div_diff, rem_next;
  logic              div_ok;
  logic [XLEN-1:0]   quo_next, quo_fix, rem_fix;
  logic [XLEN-1:0]   final_res;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
  assign mul_next  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
  assign div_shift = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q};
  assign div_ok    = ~div_diff[XLEN];
  assign rem_next  = div_ok ? div_diff : div_shift;
  assign quo_next  = {acc_q[XLEN-2:0], div_ok};
  assign prod_fix  = neg_q ? (~mul_next + 1'b1) : mul_next;
  assign quo_fix   = neg_q ? (~quo_next + 1'b1) : quo_next;
  assign rem_fix   = a_neg_q ? (~rem_next[XLEN-1:0] + 1'b1) : rem_next[XLEN-1:0];

  // Result selection applied on the last iteration
  always_comb begin
    final_res = '0;
    unique case (funct3_q)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    funct3_d   = funct3_q;
    neg_d      = neg_q;
    a_neg_d    = a_neg_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    res_d      = res_q;
    stall_ex_o = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          stall_ex_o = 1'b1;
          funct3_d   = funct3_i;
          neg_d      = a_neg ^ b_neg;
          a_neg_d    = a_neg;
          if (special) begin
            res_d   = special_res;
            state_d = StDone;
          end else begin
            cnt_d   = CNT_W'(XLEN);
            mcand_d = is_div ? abs_b : abs_a;
            acc_d   = is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
            rem_d   = '0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          stall_ex_o = 1'b1;
          cnt_d      = cnt_q - CNT_W'(1);
          if (funct3_q[2]) begin
            acc_d = {acc_q[2*XLEN-1:XLEN], quo_next};
            rem_d = rem_next;
          end else begin
            acc_d = mul_next;
          end
          if (cnt_q == CNT_W'(1)) begin
            res_d   = final_res;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          done_o = 1'b1;
          if (!hold_in_i) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign result_o = res_q;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      funct3_q <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      res_q    <= res_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed self-checking bench for ex_muldiv_seq.
module tb_ex_muldiv_seq;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        hold_in_i;
  logic        stall_ex_o;
  logic        done_o;
  logic [31:0] result_o;

  int total = 0;
  int bad   = 0;

  ex_muldiv_seq dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .flush_i    (flush_i),
    .hold_in_i  (hold_in_i),
    .stall_ex_o (stall_ex_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one op at cycle 0 and run until done (bounded); ends in the done cycle.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output logic stall0,
                       output int stall_calc);
    funct3_i = f;
    op_a_i   = a;
    op_b_i   = b;
    start_i  = 1'b1;
    #1;
    stall0     = stall_ex_o;
    stall_calc = 0;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    lat     = 1;
    while (done_o !== 1'b1 && lat < 40) begin
      if (stall_ex_o === 1'b1) stall_calc++;
      step();
      lat++;
    end
    res = result_o;
  endtask

  task automatic test_reset();
    total++;
    if (done_o !== 1'b0 || stall_ex_o !== 1'b0 || result_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got done=%b stall=%b result=%h want 0 0 00000000",
               done_o, stall_ex_o, result_o);
    end
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat; logic s0; int sc;
    do_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, r, lat, s0, sc);
    total++;
    if (r !== 32'hFFFF_FFEB) begin
      bad++; $display("FAIL mul_result: got %h want ffffffeb", r);
    end
    total++;
    if (lat !== 33) begin
      bad++; $display("FAIL mul_latency: got %0d want 33", lat);
    end
    total++;
    if (s0 !== 1'b1 || sc !== 32) begin
      bad++; $display("FAIL mul_stall: got cyc0=%b calc=%0d want 1 32", s0, sc);
    end
    total++;
    if (stall_ex_o !== 1'b0) begin
      bad++; $display("FAIL mul_stall_done: got %b want 0", stall_ex_o);
    end
    step();
    total++;
    if (done_o !== 1'b0) begin
      bad++; $display("FAIL mul_handoff: got done=%b want 0", done_o);
    end
  endtask

  task automatic test_mulh();
    logic [31:0] r; int lat; logic s0; int sc;
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, r, lat, s0, sc);
    total++;
    if (r !== 32'h4000_0000) begin
      bad++; $display("FAIL mulh: got %h want 40000000", r);
    end
    step();
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, s0, sc);
    total++;
    if (r !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL mulhu: got %h want fffffffe", r);
    end
    step();
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, s0, sc);
    total++;
    if (r !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL mulhsu: got %h want ffffffff", r);
    end
    step();
  endtask

  task automatic test_div_special();
    logic [31:0] r; int lat; logic s0; int sc;
    do_op(3'b100, 32'd20, 32'd0, r, lat, s0, sc);
    total++;
    if (r !== 32'hFFFF_FFFF || lat !== 1 || s0 !== 1'b1) begin
      bad++; $display("FAIL div_by_zero: got %h lat=%0d stall0=%b want ffffffff 1 1", r, lat, s0);
    end
    step();
    do_op(3'b111, 32'd20, 32'd0, r, lat, s0, sc);
    total++;
    if (r !== 32'h0000_0014 || lat !== 1) begin
      bad++; $display("FAIL remu_by_zero: got %h lat=%0d want 00000014 1", r, lat);
    end
    step();
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, s0, sc);
    total++;
    if (r !== 32'h8000_0000 || lat !== 1) begin
      bad++; $display("FAIL div_overflow: got %h lat=%0d want 80000000 1", r, lat);
    end
    step();
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, s0, sc);
    total++;
    if (r !== 32'h0000_0000 || lat !== 1) begin
      bad++; $display("FAIL rem_overflow: got %h lat=%0d want 00000000 1", r, lat);
    end
    step();
  endtask

  task automatic test_div();
    logic [31:0] r; int lat; logic s0; int sc;
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, lat, s0, sc);
    total++;
    if (r !== 32'hFFFF_FFFD || lat !== 33) begin
      bad++; $display("FAIL div_neg: got %h lat=%0d want fffffffd 33", r, lat);
    end
    step();
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, lat, s0, sc);
    total++;
    if (r !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL rem_neg: got %h want ffffffff", r);
    end
    step();
    do_op(3'b101, 32'd100, 32'd7, r, lat, s0, sc);
    total++;
    if (r !== 32'd14) begin
      bad++; $display("FAIL divu: got %h want 0000000e", r);
    end
    step();
    do_op(3'b111, 32'd100, 32'd7, r, lat, s0, sc);
    total++;
    if (r !== 32'd2) begin
      bad++; $display("FAIL remu: got %h want 00000002", r);
    end
    step();
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat; logic s0; int sc;
    funct3_i = 3'b101;
    op_a_i   = 32'd100;
    op_b_i   = 32'd7;
    start_i  = 1'b1;
    step();
    start_i = 1'b0;
    repeat (9) step();
    total++;
    if (stall_ex_o !== 1'b1) begin
      bad++; $display("FAIL flush_pre_stall: got %b want 1", stall_ex_o);
    end
    flush_i = 1'b1;
    #1;
    total++;
    if (stall_ex_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL flush_same_cycle: got stall=%b done=%b want 0 0", stall_ex_o, done_o);
    end
    step();
    flush_i = 1'b0;
    #1;
    total++;
    if (stall_ex_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL flush_idle: got stall=%b done=%b want 0 0", stall_ex_o, done_o);
    end
    do_op(3'b101, 32'd9, 32'd3, r, lat, s0, sc);
    total++;
    if (r !== 32'd3 || lat !== 33) begin
      bad++; $display("FAIL flush_next_op: got %h lat=%0d want 00000003 33", r, lat);
    end
    step();
  endtask

  task automatic test_hold_reset();
    logic [31:0] r; int lat; logic s0; int sc;
    do_op(3'b101, 32'd100, 32'd7, r, lat, s0, sc);
    hold_in_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (done_o !== 1'b1 || result_o !== 32'd14 || stall_ex_o !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: got done=%b stall=%b result=%h want 1 0 0000000e",
                 i, done_o, stall_ex_o, result_o);
      end
      step();
    end
    hold_in_i = 1'b0;
    #1;
    total++;
    if (done_o !== 1'b1) begin
      bad++; $display("FAIL hold_release: got done=%b want 1", done_o);
    end
    step();
    total++;
    if (done_o !== 1'b0) begin
      bad++; $display("FAIL hold_idle: got done=%b want 0", done_o);
    end
    // async reset mid-CALC
    funct3_i = 3'b000;
    op_a_i   = 32'd5;
    op_b_i   = 32'd6;
    start_i  = 1'b1;
    step();
    start_i = 1'b0;
    repeat (5) step();
    rst_ni = 1'b0;
    #1;
    total++;
    if (done_o !== 1'b0 || stall_ex_o !== 1'b0 || result_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_calc: got done=%b stall=%b result=%h want 0 0 00000000",
               done_o, stall_ex_o, result_o);
    end
    step();
    rst_ni = 1'b1;
    repeat (40) step();
    total++;
    if (done_o !== 1'b0 || result_o !== 32'h0) begin
      bad++; $display("FAIL reset_discard: got done=%b result=%h want 0 00000000", done_o, result_o);
    end
  endtask

  initial begin
    rst_ni    = 1'b0;
    start_i   = 1'b0;
    funct3_i  = 3'b000;
    op_a_i    = '0;
    op_b_i    = '0;
    flush_i   = 1'b0;
    hold_in_i = 1'b0;
    #2;
    test_reset();
    step();
    rst_ni = 1'b1;
    step();
    test_mul();
    test_mulh();
    test_div_special();
    test_div();
    test_flush();
    test_hold_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
